seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the meter's 4-digit multiplexed LED controller.
- Monitors the active-low anode lines a1..a4 and the active-low cathode bus led_seg, and rebuilds the displayed BCD digits and their binary value.
- Detects blanked (flashing) intervals and illegal segment patterns.
- Used as an in-system readback and checker for the meter display path; runs on the same 100 Hz system clock.

Parameters:
- SEG_LAG, 0, clk cycles by which led_seg lags the anode selection (0..3); the anode vector is delayed by this amount before pairing with led_seg.
- STABLE_FRAMES, 2, number of consecutive identical complete frames required before the outputs update (1..15).
- BLANK_CYC, 3, number of consecutive all-anodes-high cycles after which blank asserts (1..255).

Ports:
- clk  in  1  system clock (100 Hz)
- rst  in  1  asynchronous reset, active-low
- a1  in  1  anode, digit 1 (thousands), active-low
- a2  in  1  anode, digit 2, active-low
- a3  in  1  anode, digit 3, active-low
- a4  in  1  anode, digit 4 (ones), active-low
- led_seg  in  7  cathodes, active-low; bit6=segment a ... bit0=segment g
- val1  out  4  decoded thousands digit
- val2  out  4  decoded hundreds digit
- val3  out  4  decoded tens digit
- val4  out  4  decoded ones digit
- count  out  14  val1*1000+val2*100+val3*10+val4
- valid  out  1  one-cycle pulse when the outputs update
- blank  out  1  level; display blanked for at least BLANK_CYC cycles
- seg_err  out  1  one-cycle pulse; illegal pattern or multiple anodes active

Behaviour:
- Reset (rst=0, asynchronous): val1..val4=0, count=0, valid=0, blank=0, seg_err=0. Also clears the seen mask, capture registers, stable counter, blank counter, anode delay line (delay line resets to all-high) and the frame error flag.
- Segment decode, pattern abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other pattern is illegal.
- Each clk, classify the delayed anode vector:
  - exactly one low: capture the decoded digit into slot i and set seen[i]; an illegal pattern sets frame_err.
  - all high: blank cycle; increment blank counter (saturating at 255); clear the seen mask and frame_err (frame aborted).
  - more than one low: seg_err pulse next cycle; clear seen and frame_err; reset the stable counter.
- Any non-blank cycle clears the blank counter. blank=1 while blank counter >= BLANK_CYC; it deasserts on the first non-blank cycle.
- Frame close: on a capture cycle where seen becomes 1111.
  - frame_err=1: seg_err pulse, stable counter=0, frame discarded.
  - candidate equals the previous closed frame: stable counter++ (saturating); otherwise stable counter=1 and the candidate is stored as previous.
  - stable counter reaching STABLE_FRAMES: val*/count register the candidate, valid pulses.
  - seen and frame_err clear on every close.
- Latency: valid asserts 1 cycle after the closing capture. Outputs are registered; count is computed from registered digits in the same update.
- Repeated digit (the driver shows digit 4 twice): a later capture overwrites the slot; no error.
- Ordering: frame completion is order-independent; the last captured value per slot wins.
- Identical value held: valid pulses only once per stable run. A new pulse requires a change, then re-stabilisation.
- Arithmetic: count max 9999 fits in 14 bits; no wrap.

Optional Feature:
- Macro SEG7_BLANK_MEAS_EN.
- Defined: adds output blank_len [15:0], reset 0. On each blank-to-non-blank transition it is loaded with the length of the completed blank run in clk cycles, saturating at 65535.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Drive a scan of 1,2,3,4,4 repeating with 1234 patterns, STABLE_FRAMES=2 -> single valid pulse after the 2nd complete frame; val=1,2,3,4; count=1234; blank=0.
- Hold 0150, then switch to 0149 -> a second valid with count=149 after two frames of 0149; no extra valid while 0150 is held.
- Anodes all high for 50 cycles, then resume 0000 scan -> blank=1 from the 3rd blank cycle to the first active cycle. With SEG7_BLANK_MEAS_EN, blank_len=50.
- Digit 3 pattern 1111111 mid-scan -> seg_err pulse at frame close; no valid; the next two clean frames give valid.
- a1 and a2 low together -> seg_err pulse next cycle; partial frame discarded.
- SEG_LAG=1 with cathodes delayed one cycle, value 9999 -> count=9999; assert rst low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Readback/checker for the meter's 4-digit multiplexed LED display. It watches the active-low
//   anode lines and the active-low cathode bus. It rebuilds the four BCD digits shown and their
//   binary value, flags blanked (flashing) intervals and flags illegal segment patterns or
//   several anodes being driven at once.
//
// Optional feature: define SEG7_BLANK_MEAS_EN to add blank_len, which gives the length of the
//   most recent completed blank run.
//
// Ports
//   clk        system clock (100 Hz)
//   rst        asynchronous reset, active-low
//   a1..a4     anodes, active-low (a1 = thousands, a4 = ones)
//   led_seg    cathodes, active-low, bit6 = segment a ... bit0 = segment g
//   val1..val4 decoded digits (thousands .. ones)
//   count      val1*1000 + val2*100 + val3*10 + val4
//   valid      one-cycle pulse when val*/count update
//   blank      level, display blanked for at least BLANK_CYC cycles
//   seg_err    one-cycle pulse, illegal pattern in a frame or several anodes low
//   blank_len  (SEG7_BLANK_MEAS_EN only) length of the last completed blank run, saturating
module seg7_scan_decoder #(
    parameter int unsigned SEG_LAG       = 0,
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned BLANK_CYC     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a1,
    input  logic        a2,
    input  logic        a3,
    input  logic        a4,
    input  logic [6:0]  led_seg,
    output logic [3:0]  val1,
    output logic [3:0]  val2,
    output logic [3:0]  val3,
    output logic [3:0]  val4,
    output logic [13:0] count,
    output logic        valid,
    output logic        blank,
    output logic        seg_err
`ifdef SEG7_BLANK_MEAS_EN
    ,
    output logic [15:0] blank_len
`endif
);

    localparam logic [3:0] StableTgt = 4'(STABLE_FRAMES);
    localparam logic [7:0] BlankTgt  = 8'(BLANK_CYC);

    // bit0 = digit 1 (thousands) ... bit3 = digit 4 (ones)
    logic [3:0] an_now;
    logic [3:0] an_dly;
    assign an_now = {a4, a3, a2, a1};

    // Align the anode selection with the lagging cathode bus.
    generate
        if (SEG_LAG == 0) begin : g_no_lag
            assign an_dly = an_now;
        end else begin : g_lag
            logic [3:0] an_pipe_q [SEG_LAG];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < SEG_LAG; k++) an_pipe_q[k] <= 4'hF;
                end else begin
                    an_pipe_q[0] <= an_now;
                    for (int k = 1; k < SEG_LAG; k++) an_pipe_q[k] <= an_pipe_q[k-1];
                end
            end
            assign an_dly = an_pipe_q[SEG_LAG-1];
        end
    endgenerate

    // Returns {legal, digit}.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b0000001: r = {1'b1, 4'd0};
            7'b1001111: r = {1'b1, 4'd1};
            7'b0010010: r = {1'b1, 4'd2};
            7'b0000110: r = {1'b1, 4'd3};
            7'b1001100: r = {1'b1, 4'd4};
            7'b0100100: r = {1'b1, 4'd5};
            7'b0100000: r = {1'b1, 4'd6};
            7'b0001111: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0000100: r = {1'b1, 4'd9};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic       dec_legal;
    logic [3:0] dec_digit;
    assign {dec_legal, dec_digit} = seg_decode(led_seg);

    // Anode classification
    logic [3:0] sel;
    logic       all_high;
    logic       one_low;
    logic       multi_low;
    logic [1:0] slot_idx;

    assign sel       = ~an_dly;
    assign all_high  = (sel == 4'b0000);
    assign one_low   = !all_high && ((sel & (sel - 4'd1)) == 4'b0000);
    assign multi_low = !all_high && !one_low;

    always_comb begin
        slot_idx = 2'd0;
        unique case (sel)
            4'b0001: slot_idx = 2'd0;
            4'b0010: slot_idx = 2'd1;
            4'b0100: slot_idx = 2'd2;
            4'b1000: slot_idx = 2'd3;
            default: slot_idx = 2'd0;
        endcase
    end

    // Frame state
    logic [3:0]  seen_q, seen_d;
    logic [15:0] cap_q, cap_d;      // slot i at [4*i +: 4]
    logic [15:0] prev_q, prev_d;    // last closed error-free frame
    logic        ferr_q, ferr_d;
    logic [3:0]  stable_q, stable_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic        upd;
    logic        err;
    logic [13:0] count_calc;

    always_comb begin
        seen_d   = seen_q;
        cap_d    = cap_q;
        prev_d   = prev_q;
        ferr_d   = ferr_q;
        stable_d = stable_q;
        bcnt_d   = bcnt_q;
        upd      = 1'b0;
        err      = 1'b0;
        if (all_high) begin
            // Blank cycle aborts any partial frame.
            bcnt_d = (bcnt_q == 8'hFF) ? bcnt_q : bcnt_q + 8'd1;
            seen_d = 4'b0000;
            ferr_d = 1'b0;
        end else begin
            bcnt_d = 8'd0;
            if (multi_low) begin
                seen_d   = 4'b0000;
                ferr_d   = 1'b0;
                stable_d = 4'd0;
                err      = 1'b1;
            end else begin
                cap_d[{slot_idx, 2'b00} +: 4] = dec_digit;
                seen_d = seen_q | sel;
                ferr_d = ferr_q | !dec_legal;
                if (seen_d == 4'hF) begin
                    seen_d = 4'b0000;
                    ferr_d = 1'b0;
                    if (ferr_q || !dec_legal) begin
                        err      = 1'b1;
                        stable_d = 4'd0;
                    end else if (cap_d == prev_q) begin
                        stable_d = (stable_q == 4'hF) ? stable_q : stable_q + 4'd1;
                        // Saturated count must not re-fire on a held value.
                        upd = (stable_q != 4'hF) && (stable_d == StableTgt);
                    end else begin
                        stable_d = 4'd1;
                        prev_d   = cap_d;
                        upd      = (StableTgt == 4'd1);
                    end
                end
            end
        end
    end

    assign count_calc = 14'(cap_d[3:0])   * 14'd1000 + 14'(cap_d[7:4])  * 14'd100
                      + 14'(cap_d[11:8])  * 14'd10   + 14'(cap_d[15:12]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_q   <= 4'b0000;
            cap_q    <= 16'h0000;
            prev_q   <= 16'h0000;
            ferr_q   <= 1'b0;
            stable_q <= 4'd0;
            bcnt_q   <= 8'd0;
        end else begin
            seen_q   <= seen_d;
            cap_q    <= cap_d;
            prev_q   <= prev_d;
            ferr_q   <= ferr_d;
            stable_q <= stable_d;
            bcnt_q   <= bcnt_d;
        end
    end

    // Registered outputs
    logic [3:0]  val1_q, val2_q, val3_q, val4_q;
    logic [13:0] count_q;
    logic        valid_q, blank_q, seg_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val1_q    <= 4'd0;
            val2_q    <= 4'd0;
            val3_q    <= 4'd0;
            val4_q    <= 4'd0;
            count_q   <= 14'd0;
            valid_q   <= 1'b0;
            blank_q   <= 1'b0;
            seg_err_q <= 1'b0;
        end else begin
            valid_q   <= upd;
            seg_err_q <= err;
            blank_q   <= (bcnt_d >= BlankTgt);
            if (upd) begin
                val1_q  <= cap_d[3:0];
                val2_q  <= cap_d[7:4];
                val3_q  <= cap_d[11:8];
                val4_q  <= cap_d[15:12];
                count_q <= count_calc;
            end
        end
    end

    assign val1    = val1_q;
    assign val2    = val2_q;
    assign val3    = val3_q;
    assign val4    = val4_q;
    assign count   = count_q;
    assign valid   = valid_q;
    assign blank   = blank_q;
    assign seg_err = seg_err_q;

`ifdef SEG7_BLANK_MEAS_EN
    // Run length is tracked separately because the blank counter saturates at 255.
    logic [15:0] run_q;
    logic [15:0] blank_len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q       <= 16'd0;
            blank_len_q <= 16'd0;
        end else if (all_high) begin
            run_q <= (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;
        end else begin
            if (run_q != 16'd0) blank_len_q <= run_q;
            run_q <= 16'd0;
        end
    end

    assign blank_len = blank_len_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized scans, checked every cycle
// against a behavioural model that works on whole digits and decimal values.
module tb_seg7_scan_decoder;

    localparam int unsigned SEG_LAG       = 1;
    localparam int unsigned STABLE_FRAMES = 2;
    localparam int unsigned BLANK_CYC     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a1 = 1'b1, a2 = 1'b1, a3 = 1'b1, a4 = 1'b1;
    logic [6:0]  led_seg = 7'h7F;
    logic [3:0]  val1, val2, val3, val4;
    logic [13:0] count;
    logic        valid, blank, seg_err;
`ifdef SEG7_BLANK_MEAS_EN
    logic [15:0] blank_len;
`endif

    seg7_scan_decoder #(
        .SEG_LAG      (SEG_LAG),
        .STABLE_FRAMES(STABLE_FRAMES),
        .BLANK_CYC    (BLANK_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a1       (a1),
        .a2       (a2),
        .a3       (a3),
        .a4       (a4),
        .led_seg  (led_seg),
        .val1     (val1),
        .val2     (val2),
        .val3     (val3),
        .val4     (val4),
        .count    (count),
        .valid    (valid),
        .blank    (blank),
        .seg_err  (seg_err)
`ifdef SEG7_BLANK_MEAS_EN
        ,
        .blank_len(blank_len)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] pat_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_slot [4];
    bit         m_seen [4];
    bit         m_ferr;
    int         m_prev;
    int         m_stable;
    int         m_bcnt;
    int         m_run;
    int         m_nvalid;
    logic [3:0] m_an_hist [4];
    int         exp_val [4];
    int         exp_count;
    bit         exp_valid, exp_blank, exp_err;
    int         exp_blank_len;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_slot[k] = 0; m_seen[k] = 0; m_an_hist[k] = 4'hF; exp_val[k] = 0;
        end
        m_ferr = 0; m_prev = 0; m_stable = 0; m_bcnt = 0; m_run = 0;
        exp_count = 0; exp_valid = 0; exp_blank = 0; exp_err = 0; exp_blank_len = 0;
    endtask

    task automatic model_step();
        logic [3:0] an, cur, sel;
        int li, nlow, idx, d, v, old;
        bit match;
        exp_valid = 0;
        exp_err   = 0;
        cur = {a4, a3, a2, a1};
        li  = (SEG_LAG == 0) ? 0 : SEG_LAG - 1;
        an  = (SEG_LAG == 0) ? cur : m_an_hist[li];
        for (int k = 3; k > 0; k--) m_an_hist[k] = m_an_hist[k-1];
        m_an_hist[0] = cur;
        sel  = ~an;
        nlow = $countones(sel);
        if (nlow == 0) begin
            m_bcnt = (m_bcnt < 255) ? m_bcnt + 1 : 255;
            m_run  = (m_run < 65535) ? m_run + 1 : 65535;
            for (int k = 0; k < 4; k++) m_seen[k] = 0;
            m_ferr = 0;
        end else begin
            if (m_run > 0) exp_blank_len = m_run;
            m_run  = 0;
            m_bcnt = 0;
            if (nlow > 1) begin
                exp_err = 1;
                for (int k = 0; k < 4; k++) m_seen[k] = 0;
                m_ferr   = 0;
                m_stable = 0;
            end else begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (sel[k]) idx = k;
                d = -1;
                for (int k = 0; k < 10; k++) if (pat_tab[k] == led_seg) d = k;
                m_seen[idx] = 1;
                if (d < 0) m_ferr = 1;
                else m_slot[idx] = d;
                if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
                    if (m_ferr) begin
                        exp_err  = 1;
                        m_stable = 0;
                    end else begin
                        v     = m_slot[0] * 1000 + m_slot[1] * 100 + m_slot[2] * 10 + m_slot[3];
                        old   = m_stable;
                        match = (v == m_prev);
                        if (match) m_stable = (old < 15) ? old + 1 : 15;
                        else begin
                            m_stable = 1;
                            m_prev   = v;
                        end
                        if (m_stable == STABLE_FRAMES && (!match || old != m_stable)) begin
                            exp_valid = 1;
                            m_nvalid++;
                            for (int k = 0; k < 4; k++) exp_val[k] = m_slot[k];
                            exp_count = v;
                        end
                    end
                    for (int k = 0; k < 4; k++) m_seen[k] = 0;
                    m_ferr = 0;
                end
            end
        end
        exp_blank = (m_bcnt >= BLANK_CYC);
    endtask

    // ---------------- per-cycle compare ----------------
    int n_valid = 0;
    int n_err   = 0;

    initial begin
        model_reset();
        m_nvalid = 0;
        forever begin
            @(posedge clk);
            if (!rst) model_reset();
            else model_step();
            #1;
            if (valid) n_valid++;
            if (seg_err) n_err++;
            chk("val1", val1, exp_val[0]);
            chk("val2", val2, exp_val[1]);
            chk("val3", val3, exp_val[2]);
            chk("val4", val4, exp_val[3]);
            chk("count", count, exp_count);
            chk("valid", valid, exp_valid);
            chk("blank", blank, exp_blank);
            chk("seg_err", seg_err, exp_err);
`ifdef SEG7_BLANK_MEAS_EN
            chk("blank_len", blank_len, exp_blank_len);
`endif
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] pat_q [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};

    // One display cycle; the cathodes follow the anodes SEG_LAG cycles later.
    task automatic cyc(input logic [3:0] an, input logic [6:0] pat);
        @(negedge clk);
        for (int k = 3; k > 0; k--) pat_q[k] = pat_q[k-1];
        pat_q[0] = pat;
        {a4, a3, a2, a1} = an;
        led_seg = pat_q[SEG_LAG];
    endtask

    function automatic int digit_of(input int v, input int s);
        int r;
        case (s)
            0:       r = v / 1000;
            1:       r = (v / 100) % 10;
            2:       r = (v / 10) % 10;
            default: r = v % 10;
        endcase
        return r;
    endfunction

    // Scan 1,2,3,4,4; bad_slot >= 0 shows an illegal pattern on that digit.
    task automatic scan(input int v, input int bad_slot);
        int s;
        for (int i = 0; i < 5; i++) begin
            s = (i == 4) ? 3 : i;
            if (s == bad_slot) cyc(~(4'b0001 << s), 7'h7F);
            else cyc(~(4'b0001 << s), pat_tab[digit_of(v, s)]);
        end
    endtask

    // Extra repeat of digit 4 so a just-closed frame's pulse has been observed.
    task automatic tick(input int v);
        cyc(4'b0111, pat_tab[digit_of(v, 3)]);
        cyc(4'b0111, pat_tab[digit_of(v, 3)]);
    endtask

    task automatic scan_rand(input int v, input int bad_slot);
        int ord [4];
        int j, t, s;
        for (int k = 0; k < 4; k++) ord[k] = k;
        for (int k = 3; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = ord[k]; ord[k] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < 5; i++) begin
            s = (i == 4) ? ord[$urandom_range(0, 3)] : ord[i];
            if (s == bad_slot) cyc(~(4'b0001 << s), 7'h7F);
            else cyc(~(4'b0001 << s), pat_tab[digit_of(v, s)]);
        end
    endtask

    initial begin
        int nv, ne, v, kind;
        logic [3:0] mv;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_val1", val1, 0);
        chk("rst_valid", valid, 0);
        chk("rst_blank", blank, 0);
        chk("rst_seg_err", seg_err, 0);
        rst = 1'b1;

        // 1234 held: one valid after the second frame
        repeat (3) scan(1234, -1);
        tick(1234);
        chk("lit_1234_nvalid", n_valid, 1);
        chk("lit_1234_model_nvalid", m_nvalid, 1);
        chk("lit_1234_count", count, 1234);
        chk("lit_1234_model_count", exp_count, 1234);
        chk("lit_1234_val1", val1, 1);
        chk("lit_1234_val2", val2, 2);
        chk("lit_1234_val3", val3, 3);
        chk("lit_1234_val4", val4, 4);
        chk("lit_1234_blank", blank, 0);

        // 0150 held, then 0149
        repeat (4) scan(150, -1);
        tick(150);
        chk("lit_0150_nvalid", n_valid, 2);
        chk("lit_0150_count", count, 150);
        repeat (3) scan(149, -1);
        tick(149);
        chk("lit_0149_nvalid", n_valid, 3);
        chk("lit_0149_count", count, 149);

        // 50 blank cycles then 0000
        repeat (50) cyc(4'hF, 7'h7F);
        chk("lit_blank_hi", blank, 1);
        chk("lit_blank_model", exp_blank, 1);
        repeat (3) scan(0, -1);
        tick(0);
        chk("lit_blank_lo", blank, 0);
        chk("lit_0000_nvalid", n_valid, 4);
`ifdef SEG7_BLANK_MEAS_EN
        chk("lit_blank_len", blank_len, 50);
`endif

        // Illegal pattern on digit 3
        ne = n_err;
        scan(5678, 2);
        tick(5678);
        chk("lit_illegal_err", n_err, ne + 1);
        chk("lit_illegal_novalid", n_valid, 4);
        repeat (2) scan(5678, -1);
        tick(5678);
        chk("lit_after_illegal_nvalid", n_valid, 5);
        chk("lit_after_illegal_count", count, 5678);

        // a1 and a2 low together mid-frame
        ne = n_err;
        cyc(4'b1110, pat_tab[5]);
        cyc(4'b1101, pat_tab[6]);
        cyc(4'b1100, pat_tab[7]);
        cyc(4'b1011, pat_tab[7]);
        tick(5678);
        chk("lit_multi_err", n_err, ne + 1);
        chk("lit_multi_novalid", n_valid, 5);
        repeat (2) scan(5678, -1);
        tick(5678);
        chk("lit_after_multi_nvalid", n_valid, 6);

        // Randomized scans with occasional glitches
        v = 0;
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) != 0) v = $urandom_range(0, 9999);
            for (int r = 0; r < int'($urandom_range(1, 4)); r++) begin
                kind = $urandom_range(0, 19);
                if (kind == 1) begin
                    do mv = 4'($urandom_range(0, 15)); while ($countones(~mv) < 2);
                    cyc(mv, pat_tab[$urandom_range(0, 9)]);
                end else if (kind == 2) begin
                    repeat ($urandom_range(1, 6)) cyc(4'hF, 7'h7F);
                end
                scan_rand(v, (kind == 0) ? int'($urandom_range(0, 3)) : -1);
            end
        end

        // 9999 through the lagged path, then asynchronous reset mid-frame
        nv = n_valid;
        repeat (3) scan(9999, -1);
        tick(9999);
        chk("lit_9999_count", count, 9999);
        chk("lit_9999_val4", val4, 9);
        cyc(4'b1110, pat_tab[9]);
        cyc(4'b1101, pat_tab[9]);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("lit_async_count", count, 0);
        chk("lit_async_val1", val1, 0);
        chk("lit_async_valid", valid, 0);
        chk("lit_async_blank", blank, 0);
        chk("lit_async_seg_err", seg_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) scan(42, -1);
        tick(42);
        chk("lit_post_rst_count", count, 42);
        chk("lit_9999_seen", (n_valid > nv) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
